// File: rtl/note_scheduler.sv
// Round-robin scheduler sharing one wave-generator voice among N_REQ note requesters.
// Define NOTE_SCHED_PREEMPT_EN to let another requester truncate a playing note.
module note_scheduler #(
  parameter int N_REQ      = 4,
  parameter int HZ_W       = 32,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*HZ_W-1:0]    req_hz,
  input  logic [N_REQ*4-1:0]       req_dur,
  output logic [N_REQ-1:0]         grant,
  output logic                     gen_reset,
  output logic                     gen_play,
  output logic [HZ_W-1:0]          gen_hz,
  output logic [3:0]               gen_dur,
  output logic [$clog2(N_REQ)-1:0] active_id,
  output logic                     busy
);
  // state | meaning
  // IDLE  | waiting for a request; arbitrates and latches the winner
  // LOAD  | one-cycle generator load strobe, counters primed
  // PLAY  | generator enabled for gen_dur ticks of TICK_DIV cycles
  // GAP   | silent spacing before the next arbitration
  localparam int ID_W = $clog2(N_REQ);
  localparam int TW   = $clog2(TICK_DIV);
  localparam int GW   = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t           state, state_n;
  logic [ID_W-1:0]  last, last_n, id_n, win;
  logic             found;
  logic [TW-1:0]    tick_cnt, tick_n;
  logic [3:0]       unit_cnt, unit_n, dur_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic [HZ_W-1:0]  hz_n;
  logic [N_REQ-1:0] grant_n;
  logic             preempt;
  logic [HZ_W-1:0]  hz_arr  [N_REQ];
  logic [3:0]       dur_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign hz_arr[i]  = req_hz[i*HZ_W +: HZ_W];
    assign dur_arr[i] = req_dur[i*4 +: 4];
  end

`ifdef NOTE_SCHED_PREEMPT_EN
  logic [N_REQ-1:0] active_mask;
  assign active_mask = N_REQ'(1) << active_id;
  assign preempt     = |(req & ~active_mask);
`else
  assign preempt = 1'b0;
`endif

  // Search starts one past the last winner and wraps, giving round-robin fairness.
  always_comb begin : arbiter
    int c;
    logic [ID_W-1:0] cidx;
    found = 1'b0;
    win   = '0;
    c     = 0;
    cidx  = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      c    = (int'(last) + off) % N_REQ;
      cidx = ID_W'(c);
      if (!found && req[cidx]) begin
        found = 1'b1;
        win   = cidx;
      end
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    id_n    = active_id;
    hz_n    = gen_hz;
    dur_n   = gen_dur;
    tick_n  = tick_cnt;
    unit_n  = unit_cnt;
    gap_n   = gap_cnt;
    grant_n = '0;
    case (state)
      IDLE: begin
        if (found) begin
          last_n       = win;
          id_n         = win;
          hz_n         = hz_arr[win];
          dur_n        = dur_arr[win];
          grant_n[win] = 1'b1;
          // A zero-length note skips the generator; the grant cycle adds one to the gap.
          if (dur_arr[win] == 4'd0) begin
            state_n = GAP;
            gap_n   = GW'(GAP_CYCLES);
          end else begin
            state_n = LOAD;
          end
        end
      end
      LOAD: begin
        tick_n  = TW'(TICK_DIV - 1);
        unit_n  = gen_dur;
        state_n = PLAY;
      end
      PLAY: begin
        if (preempt || (tick_cnt == '0 && unit_cnt == 4'd1)) begin
          state_n = GAP;
          gap_n   = GW'(GAP_CYCLES - 1);
        end else if (tick_cnt == '0) begin
          tick_n = TW'(TICK_DIV - 1);
          unit_n = unit_cnt - 4'd1;
        end else begin
          tick_n = tick_cnt - TW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - GW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last      <= ID_W'(N_REQ - 1);
      active_id <= '0;
      gen_hz    <= '0;
      gen_dur   <= '0;
      tick_cnt  <= '0;
      unit_cnt  <= '0;
      gap_cnt   <= '0;
      grant     <= '0;
      gen_reset <= 1'b0;
      gen_play  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      last      <= last_n;
      active_id <= id_n;
      gen_hz    <= hz_n;
      gen_dur   <= dur_n;
      tick_cnt  <= tick_n;
      unit_cnt  <= unit_n;
      gap_cnt   <= gap_n;
      grant     <= grant_n;
      gen_reset <= (state_n == LOAD);
      gen_play  <= (state_n == PLAY);
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Self-checking bench for note_scheduler with N_REQ=4, TICK_DIV=4, GAP_CYCLES=2.
module tb_note_scheduler;
  localparam int N_REQ = 4, HZ_W = 32, TICK_DIV = 4, GAP_CYCLES = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [127:0] req_hz;
  logic [15:0] req_dur;
  logic [3:0]  grant;
  logic        gen_reset, gen_play;
  logic [31:0] gen_hz;
  logic [3:0]  gen_dur;
  logic [1:0]  active_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  note_scheduler #(.N_REQ(N_REQ), .HZ_W(HZ_W), .TICK_DIV(TICK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clock(clock), .reset(reset), .req(req), .req_hz(req_hz), .req_dur(req_dur),
    .grant(grant), .gen_reset(gen_reset), .gen_play(gen_play), .gen_hz(gen_hz),
    .gen_dur(gen_dur), .active_id(active_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 200 && busy; c++) @(negedge clock);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      n++;
      if (grant != 4'd0) break;
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] dur;
    logic [3:0]  exp_grant;
    logic [31:0] exp_hz;
    logic [3:0]  exp_dur;
    logic [1:0]  exp_id;
    int          exp_play;
    int          exp_busy;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int play, resets, nbusy, n, t, prev, bad;
    logic [31:0] prev_hz;

    vecs[0] = '{4'b0001, 16'h3333, 4'b0001, 32'd440, 4'd3, 2'd0, 12, 15};
    vecs[1] = '{4'b0011, 16'h1111, 4'b0010, 32'd494, 4'd1, 2'd1,  4,  7};
    vecs[2] = '{4'b0011, 16'h1111, 4'b0001, 32'd440, 4'd1, 2'd0,  4,  7};
    vecs[3] = '{4'b0100, 16'h0000, 4'b0100, 32'd523, 4'd0, 2'd2,  0,  3};
    vecs[4] = '{4'b1010, 16'h2222, 4'b1000, 32'd587, 4'd2, 2'd3,  8, 11};
    vecs[5] = '{4'b1010, 16'h2222, 4'b0010, 32'd494, 4'd2, 2'd1,  8, 11};
    vecs[6] = '{4'b1111, 16'h2415, 4'b0100, 32'd523, 4'd4, 2'd2, 16, 19};
    vecs[7] = '{4'b1001, 16'h2415, 4'b1000, 32'd587, 4'd2, 2'd3,  8, 11};

    req     = 4'd0;
    req_dur = 16'h0000;
    req_hz  = {32'd587, 32'd523, 32'd494, 32'd440};
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_outputs", {25'd0, gen_reset, gen_play, busy, gen_dur}, 32'd0);
    chk("rst_hz", gen_hz, 32'd0);
    chk("rst_id", 32'(active_id), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Table-driven single notes, each started from IDLE.
    for (int i = 0; i < 8; i++) begin
      req_dur = vecs[i].dur;
      req     = vecs[i].req;
      @(negedge clock);
      chk("vec_grant", 32'(grant), 32'(vecs[i].exp_grant));
      chk("vec_gen_reset", 32'(gen_reset), 32'(vecs[i].exp_dur != 4'd0));
      chk("vec_hz", gen_hz, vecs[i].exp_hz);
      chk("vec_dur", 32'(gen_dur), 32'(vecs[i].exp_dur));
      chk("vec_id", 32'(active_id), 32'(vecs[i].exp_id));
      req    = 4'd0;
      play   = 0;
      resets = int'(gen_reset);
      nbusy  = int'(busy);
      for (int c = 0; c < 200 && busy; c++) begin
        @(negedge clock);
        if (busy) begin
          nbusy++;
          play   += int'(gen_play);
          resets += int'(gen_reset);
        end
      end
      chk("vec_play_cycles", 32'(play), 32'(vecs[i].exp_play));
      chk("vec_busy_cycles", 32'(nbusy), 32'(vecs[i].exp_busy));
      chk("vec_reset_count", 32'(resets), 32'(vecs[i].exp_dur != 4'd0));
      chk("vec_hz_held", gen_hz, vecs[i].exp_hz);
    end

    // Round-robin with all requests held.
    req_dur = 16'h1111;
    req     = 4'b1111;
    t = 0; prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant(n);
      t += n;
      chk("rr_grant", 32'(grant), 32'(4'b0001 << (g % 4)));
      if (g > 0) chk("rr_spacing", 32'(t - prev), 32'd8);
      prev = t;
    end
    req = 4'd0;
    wait_idle();

    // Held single request; pitch changes mid-note must wait for the next grant.
    req     = 4'b0010;
    t = 0; prev = 0; bad = 0;
    prev_hz = gen_hz;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clock);
        n++;
        if (gen_hz != prev_hz && grant == 4'd0) bad++;
        prev_hz = gen_hz;
        if (grant != 4'd0) break;
      end
      t += n;
      chk("held_grant", 32'(grant), 32'd2);
      chk("held_hz", gen_hz, (g == 0) ? 32'd494 : 32'd1000);
      if (g > 0) chk("held_spacing", 32'(t - prev), 32'd8);
      prev = t;
      if (g == 0) begin
        @(negedge clock);
        t++;
        if (gen_hz != prev_hz) bad++;
        req_hz[63:32] = 32'd1000;
      end
    end
    req = 4'd0;
    wait_idle();
    chk("held_hz_only_on_grant", 32'(bad), 32'd0);
    req_hz[63:32] = 32'd494;

    // Reset in the middle of a note restores the pointer.
    req_dur = 16'h3333;
    req     = 4'b0100;
    @(negedge clock);
    chk("mid_grant", 32'(grant), 32'd4);
    req = 4'd0;
    repeat (5) @(negedge clock);
    chk("mid_playing", 32'(gen_play), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_outputs", {24'd0, grant, gen_reset, gen_play, busy, 1'b0}, 32'd0);
    chk("mid_rst_hz_dur", gen_hz | 32'(gen_dur) | 32'(active_id), 32'd0);
    req = 4'b1001;
    @(negedge clock);
    chk("mid_ptr_grant0", 32'(grant), 32'd1);
    req = 4'b1000;
    wait_grant(n);
    chk("mid_ptr_grant3", 32'(grant), 32'd8);
    req = 4'd0;
    wait_idle();

    // A different requester arriving during PLAY.
    req_dur = 16'h0005;
    req     = 4'b0001;
    @(negedge clock);
    chk("pre_grant0", 32'(grant), 32'd1);
    req  = 4'd0;
    play = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (!gen_play) break;
      play++;
      if (play == 3) req = 4'b0100;
    end
`ifdef NOTE_SCHED_PREEMPT_EN
    chk("pre_play_cycles", 32'(play), 32'd3);
`else
    chk("pre_play_cycles", 32'(play), 32'd20);
`endif
    n = 1;
    for (int c = 0; c < 50 && grant == 4'd0; c++) begin
      @(negedge clock);
      n++;
    end
    chk("pre_gap_to_grant", 32'(n), 32'd4);
    chk("pre_grant2", 32'(grant), 32'd4);
    chk("pre_hz", gen_hz, 32'd523);
    req = 4'd0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/note_scheduler.md
# note_scheduler

Round-robin scheduler that shares one wave-generator voice (the piano/music-box note synthesizer) between `N_REQ` note requesters, such as piano keys or the music-box sequencer. It arbitrates pending requests and latches the winner's pitch and duration. It then sequences the generator through load, play and silence-gap phases, timing note length in units of `TICK_DIV` clock cycles. It sits between the key/sequencer front-end and the single wave generator, and drives that generator's `reset`, `play_note`, `hz` and `duration` inputs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `HZ_W`, 32: pitch word width, passed through to the generator.
- `TICK_DIV`, 50000: clock cycles per duration unit, ≥2.
- `GAP_CYCLES`, 2: silent cycles after each note, ≥1.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in `N_REQ`: level request per requester.
- `req_hz` in `N_REQ*HZ_W`: packed pitch words, requester i at `[i*HZ_W +: HZ_W]`.
- `req_dur` in `N_REQ*4`: packed durations in ticks, requester i at `[i*4 +: 4]`.
- `grant` in/out: out `N_REQ`: one-hot, high exactly one cycle when a request is accepted.
- `gen_reset` out 1: generator load strobe.
- `gen_play` out 1: generator enable.
- `gen_hz` out `HZ_W`: latched pitch.
- `gen_dur` out 4: latched duration.
- `active_id` out `$clog2(N_REQ)`: index of the last granted requester.
- `busy` out 1: high when the FSM is in any state other than IDLE.

## Operation
- FSM states are IDLE, LOAD, PLAY and GAP. All outputs are registered.
- Reset:
  - State goes to IDLE.
  - `grant`, `gen_reset`, `gen_play`, `gen_hz`, `gen_dur`, `active_id` and `busy` all go to 0.
  - The round-robin pointer `last` is set to `N_REQ-1`, so requester 0 has top priority first.
- IDLE, when `req` is nonzero:
  - The winner is the first set bit searching `last+1, last+2, …`, wrapping modulo `N_REQ`.
  - The winner's `req_hz` and `req_dur` are latched into `gen_hz` and `gen_dur`.
  - `last` and `active_id` are set to the winner.
  - `grant[winner]` is set.
  - If the latched duration is 0, the FSM goes to GAP (grant still issued, no note played). Otherwise it goes to LOAD.
- IDLE with no request: the FSM stays in IDLE.
- LOAD, lasting one cycle:
  - `gen_reset` is 1 and `gen_play` is 0.
  - The tick counter is loaded with `TICK_DIV-1` and the unit counter with `gen_dur`.
  - Next state is PLAY.
- PLAY:
  - `gen_play` is 1.
  - The tick counter decrements each cycle. At 0 it reloads to `TICK_DIV-1` and the unit counter decrements.
  - When the tick counter is 0 and the unit counter is 1, the FSM goes to GAP. PLAY therefore lasts exactly `gen_dur*TICK_DIV` cycles.
- GAP:
  - `gen_play` is 0 and the gap counter runs `GAP_CYCLES` cycles.
  - The FSM then returns to IDLE.
- `req` is sampled only in IDLE. A requester that keeps `req` high after its grant is served again as a new note, subject to round-robin order.
- Latched `gen_hz` and `gen_dur` hold their values until the next grant. They do not clear in GAP or IDLE.
- Counter widths:
  - Tick counter: `$clog2(TICK_DIV)` bits.
  - Unit counter: 4 bits.
  - Gap counter: `$clog2(GAP_CYCLES+1)` bits.
  - No arithmetic is done on `hz`; it is passed through only.
- `reset` asserted in any state overrides everything. The note is cut with no GAP, and the pointer resets.

## Timing
- A request sampled in IDLE at edge k produces the following cycles:
  - Cycle k+1: LOAD, with `grant`, `gen_reset` and `busy` all 1.
  - Cycles k+2 .. k+1+dur*`TICK_DIV`: `gen_play` is 1.
  - The next `GAP_CYCLES` cycles: `gen_play` is 0.
  - Then IDLE, where a new request can be sampled.
- Minimum spacing between consecutive grants is `2 + dur*TICK_DIV + GAP_CYCLES` cycles.
- A zero-duration request produces `grant` in the cycle after sampling, then `GAP_CYCLES` cycles, then IDLE. No `gen_reset` and no `gen_play` are produced.

## Configuration
- `NOTE_SCHED_PREEMPT_EN` undefined:
  - A note always plays to completion.
  - Requests arriving during LOAD or PLAY wait for IDLE.
- `NOTE_SCHED_PREEMPT_EN` defined:
  - In PLAY, if `req` has any bit set other than `active_id`, the FSM goes to GAP on the next edge and the note is truncated.
  - Normal round-robin arbitration follows in IDLE.
  - A request from the active requester itself never preempts.

## Test plan
All scenarios use `N_REQ=4`, `TICK_DIV=4` and `GAP_CYCLES=2`.
1. Reset, then single request: `req=0001`, dur=3, hz=440.
   - `grant=0001` and `gen_reset=1` for one cycle.
   - `gen_hz=440`, `gen_dur=3`.
   - `gen_play` high exactly 12 cycles, then 2 silent cycles, then `busy=0`.
2. Round-robin: `req=1111` held high, dur=1.
   - Grants occur in order 0001, 0010, 0100, 1000, 0001.
   - Grants are spaced 8 cycles apart.
3. Zero duration: `req=0100`, dur=0.
   - `grant=0100` for one cycle.
   - `gen_reset` and `gen_play` never assert.
   - `busy` stays high for 3 cycles total.
4. Reset mid-note: assert `reset` for 1 cycle on the 5th cycle of PLAY.
   - Next cycle: all outputs 0 and state IDLE.
   - A following `req=1000` is granted only after `req` bit 0 would have been served first, showing the pointer was reset.
5. Preempt (macro defined): requester 0 playing dur=5, then `req[2]` rises on PLAY cycle 3.
   - `gen_play` falls on the next cycle.
   - GAP lasts 2 cycles, then `grant=0100`.
   - Macro undefined: the full 20 PLAY cycles complete first.
6. Held request: `req=0010` held high, dur=1.
   - Grants repeat every 8 cycles.
   - `gen_hz` updates only on grant cycles.
